// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the shift-and-add multiplier front end.
package mult_pkg;

  localparam int MULT_W  = 8;
  localparam int MULT_CW = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CAPT,
    RESP
  } state_t;

  // One partial product per clock, so the shift phase lasts one cycle per operand bit.
  function automatic int shift_count(input int w);
    return w;
  endfunction

endpackage

// File: rtl/mult_seq_arb_if.sv
// Request/response bundle between two requesters, the front end and one consumer.
interface mult_seq_arb_if
  import mult_pkg::*;
#(
  parameter int W = MULT_W
);

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] rsp_y;
  logic           rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves past the winner on each accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic       accept,
  output logic       id
);

  logic ptr;

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
    id     = ptr;
    accept = 1'b0;
    ready  = 2'b00;
    if (!valid[ptr]) id = ~ptr;
    if (en && valid[id]) begin
      accept    = 1'b1;
      ready[id] = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (accept) ptr <= ~id;
  end

endmodule

// File: rtl/mult_seq_arb.sv
// Arbitrated front end: accepts one request, sequences the external multiplier, returns the product.
module mult_seq_arb
  import mult_pkg::*;
#(
  parameter int W  = MULT_W,
  parameter int CW = MULT_CW
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_seq_arb_if.slave  bus,
  output logic           busy,
  output logic           mul_load,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y
);

  localparam int            NSHIFT = shift_count(W);
  localparam logic [CW-1:0] LAST   = CW'(NSHIFT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          id_q;
  logic          accept;
  logic          grant_id;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == IDLE),
    .valid  (bus.req_valid),
    .ready  (bus.req_ready),
    .accept (accept),
    .id     (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    bus.rsp_valid = (state == RESP);
    unique case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mul_load is decoded from the next state and registered, so it is a clean one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_load   <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      id_q       <= 1'b0;
      cnt        <= '0;
      bus.rsp_y  <= '0;
      bus.rsp_id <= 1'b0;
    end else begin
      mul_load <= (state_nxt == LOAD);
      if (accept) begin
        mul_a <= grant_id ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
        mul_b <= grant_id ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
        id_q  <= grant_id;
      end
      if (state == LOAD)       cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + 1'b1;
      if (state == CAPT) begin
        bus.rsp_y  <= mul_y;
        bus.rsp_id <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_arb.sv
// Bench for mult_seq_arb driving a shift-and-add multiplier, checked against a transaction-level model.
module tb_mult_seq_arb;
  import mult_pkg::*;

  localparam int W = MULT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_arb_if #(.W(W)) bus ();

  logic           busy, mul_load;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_y;

  mult_seq_arb #(.W(W), .CW(MULT_CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .mul_load (mul_load),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_y    (mul_y)
  );

  // Shift-and-add multiplier: load clears and takes B, then one partial product per clock.
  logic [2*W-1:0] acc = '0, a_sh = '0;
  logic [W-1:0]   b_sh = '0;
  always @(posedge clk) begin
    if (mul_load) begin
      acc  <= '0;
      a_sh <= {{W{1'b0}}, mul_a};
      b_sh <= mul_b;
    end else begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
    end
  end
  assign mul_y = acc;

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction model: one job in flight, m_since counts cycles since its accept edge.
  bit         m_busy = 1'b0;
  bit         m_ptr = 1'b0;
  bit         m_id = 1'b0;
  int         m_since = 0;
  logic [7:0] m_a = '0, m_b = '0;
  int         n_acc = 0;
  int         n_rsp_dut = 0;

  function automatic int m_grant();
    if (m_busy) return -1;
    if (bus.req_valid[m_ptr]) return int'(m_ptr);
    if (bus.req_valid[!m_ptr]) return int'(!m_ptr);
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_ptr   <= 1'b0;
      m_since <= 0;
    end else if (!m_busy) begin
      g = m_grant();
      if (g >= 0) begin
        m_busy  <= 1'b1;
        m_since <= 0;
        m_id    <= g[0];
        m_a     <= bus.req_a[g*W +: W];
        m_b     <= bus.req_b[g*W +: W];
        m_ptr   <= !g[0];
        n_acc   <= n_acc + 1;
      end
    end else if (m_since >= W + 2 && bus.rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_since <= m_since + 1;
    end
  end

  always @(negedge clk) begin
    int         g;
    logic [1:0] exp_rdy;
    logic [15:0] exp_y;
    if (!rst_n) begin
      check("rst_busy", 32'(busy), 0);
      check("rst_mul_load", 32'(mul_load), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_y", 32'(bus.rsp_y), 0);
    end else begin
      g = m_grant();
      exp_rdy = (g >= 0) ? 2'(1 << g) : 2'b00;
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_busy));
      check("mul_load", 32'(mul_load), 32'(m_busy && m_since == 0));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_busy && m_since >= W + 2));
      if (m_busy) check("mul_a", 32'(mul_a), 32'(m_a));
      if (m_busy && m_since == 0) check("mul_b", 32'(mul_b), 32'(m_b));
      if (m_busy && m_since >= W + 2) begin
        exp_y = 16'(m_a) * 16'(m_b);
        check("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
        check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      end
      if (bus.rsp_valid && bus.rsp_ready) n_rsp_dut++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one request, wait for its response and check it against a literal product.
  task automatic send(input bit id, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_y, input bit chk_lat);
    bit got;
    int lat, loads;
    bus.req_a[id*W +: W] = a;
    bus.req_b[id*W +: W] = b;
    bus.req_valid[id]    = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
      else step();
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      bus.req_valid[id] = 1'b0;
      return;
    end
    step();
    bus.req_valid[id] = 1'b0;
    lat = -1;
    loads = 0;
    for (int i = 0; i < 100 && lat < 0; i++) begin
      @(negedge clk);
      if (mul_load) loads++;
      if (bus.rsp_valid) lat = i;
    end
    if (lat < 0) begin
      check("rsp_timeout", 0, 1);
    end else begin
      if (chk_lat) check("latency", 32'(lat), 32'(W + 2));
      check("load_pulses", 32'(loads), 1);
      check("lit_rsp_y", 32'(bus.rsp_y), 32'(exp_y));
      check("lit_rsp_id", 32'(bus.rsp_id), 32'(id));
    end
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ids[$];
    int acc_base, rsp_base, cycles;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();
    check("reset_mul_a", 32'(mul_a), 0);
    check("reset_rsp_id", 32'(bus.rsp_id), 0);
    rst_n = 1'b1;
    step();

    send(1'b0, 8'h0D, 8'h0B, 16'h008F, 1'b1);

    send(1'b1, 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    send(1'b1, 8'h00, 8'hA5, 16'h0000, 1'b1);
    send(1'b1, 8'h80, 8'h02, 16'h0100, 1'b1);
    send(1'b1, 8'h01, 8'hFF, 16'h00FF, 1'b1);

    // Both requesters held valid: grants must alternate starting from requester 0.
    bus.req_a = {8'd7, 8'd3};
    bus.req_b = {8'd9, 8'd5};
    bus.req_valid = 2'b11;
    for (int c = 0; c < 100 && ids.size() < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready[0]) ids.push_back(0);
      if (bus.req_ready[1]) ids.push_back(1);
      if (bus.rsp_valid) check("alt_y", 32'(bus.rsp_y), bus.rsp_id ? 32'h003F : 32'h000F);
      step();
    end
    check("alt_count", 32'(ids.size()), 4);
    for (int i = 0; i < ids.size(); i++) check("alt_order", 32'(ids[i]), 32'(i % 2));
    bus.req_valid = 2'b00;
    repeat (15) step();

    // Backpressure: response held for 20 cycles with both requesters waiting.
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h21, 8'h03, 16'h0063, 1'b1);
    bus.req_a = {8'h02, 8'h02};
    bus.req_b = {8'h04, 8'h04};
    bus.req_valid = 2'b11;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.rsp_valid), 1);
      check("bp_y", 32'(bus.rsp_y), 32'h0063);
      check("bp_id", 32'(bus.rsp_id), 0);
      check("bp_busy", 32'(busy), 1);
      check("bp_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_idle", 32'(busy), 0);
    check("bp_regrant", 32'(bus.req_ready), 32'h2);
    step();
    @(negedge clk);
    check("bp_accepted", 32'(busy), 1);
    bus.req_valid = 2'b00;
    repeat (15) step();

    // Reset while the counter is at 4 abandons the job.
    bus.req_a[7:0] = 8'h55;
    bus.req_b[7:0] = 8'h66;
    bus.req_valid[0] = 1'b1;
    for (int i = 0; i < 20 && !bus.req_ready[0]; i++) step();
    step();
    bus.req_valid[0] = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_mul_load", 32'(mul_load), 0);
    check("arst_mul_a", 32'(mul_a), 0);
    check("arst_mul_b", 32'(mul_b), 0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("arst_rsp_y", 32'(bus.rsp_y), 0);
    check("arst_rsp_id", 32'(bus.rsp_id), 0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(bus.rsp_valid), 0);
      step();
    end
    send(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);

    // Random traffic; the model checks every response on the fly.
    acc_base = n_acc;
    rsp_base = n_rsp_dut;
    cycles = 0;
    while (n_acc - acc_base < 1000 && cycles < 40000) begin
      bus.req_valid = 2'($urandom);
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      cycles++;
    end
    check("rand_accepts", 32'(n_acc - acc_base >= 1000), 1);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (20) step();
    check("rand_rsp_count", 32'(n_rsp_dut - rsp_base), 32'(n_acc - acc_base));
    check("drained_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_seq_arb.md
Name: mult_seq_arb

Overview:
- Two-requester front end for the 8-bit shift-and-add multiplier (one partial product per clk, operand B consumed LSB first).
- Arbitrates round-robin between two valid/ready requesters and latches the winner's operands.
- Generates the multiplier's registered load pulse and counts the shift cycles.
- Captures the 16-bit product and returns it on a valid/ready response channel tagged with the requester id.

Parameters:
- W, 8, operand width; product is 2*W bits. Shift cycle count equals W.
- CW, 4, width of shift counter; must satisfy 2**CW > W.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept (combinational)
- req_a  in  2*W  operand A; requester i in bits [i*W +: W]
- req_b  in  2*W  operand B; same packing
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts product
- rsp_y  out  2*W  product
- rsp_id  out  1  index of requester that issued the product
- busy  out  1  high in every state except IDLE
- mul_load  out  1  to multiplier slow/load input; registered, glitch-free
- mul_a  out  W  to multiplier A; held stable for the whole operation
- mul_b  out  W  to multiplier B; sampled by the multiplier during LOAD
- mul_y  in  2*W  multiplier product

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, rr_ptr=0.
  - mul_load=0, mul_a=0, mul_b=0.
  - rsp_valid=0, rsp_y=0, rsp_id=0, busy=0.
  - Reset mid-operation abandons the operation; no response is produced for it.
- States: IDLE, LOAD, SHIFT, CAPT, RESP.
- Arbitration (IDLE only):
  - grant = requester rr_ptr if it is valid, else the other one if valid.
  - req_ready[i] = (state==IDLE) && grant==i. Never both high. Both low outside IDLE.
  - Accept edge (valid && ready): latch a/b into mul_a/mul_b, latch id, set rr_ptr = ~id. State goes to LOAD.
  - With a single active requester, that requester is granted back-to-back.
- Timing (cycle k = cycle after accept edge E0):
  - Cycle 0, LOAD: mul_load=1 (registered, so it is high exactly this cycle). Multiplier clears and latches B at E1.
  - Cycles 1..W, SHIFT: mul_load=0. Counter runs 0..W-1 and exits to CAPT after count W-1.
  - Cycle W+1, CAPT: mul_y is stable. At the next edge, rsp_y<=mul_y and rsp_id<=latched id.
  - Cycle W+2, RESP: rsp_valid=1. rsp_y and rsp_id are held constant until rsp_ready. On the handshake edge, go to IDLE.
- Latency: rsp_valid rises W+2 cycles after the accept edge (10 for W=8).
- Throughput: with rsp_ready tied high, one accept per W+4 cycles.
- Backpressure: RESP may last indefinitely; requests stall (ready low) meanwhile.
- mul_a/mul_b keep their last value outside an operation.
- Arithmetic: unsigned; product = a*b, full 2*W bits, no truncation. Examples: 0xFF*0xFF=0xFE01; any operand 0 gives 0.
- Simultaneous events:
  - Request valid during RESP: not accepted until IDLE is reached.
  - Both valid in IDLE: rr_ptr decides.
  - Valid deasserted before accept: nothing happens (no commitment before handshake).

Decomposition:
- Shared package (mult_pkg): W default, state encoding localparams (IDLE/LOAD/SHIFT/CAPT/RESP), and the function computing shift count from W.
- One natural sub-module, rr_arb2: 2-input round-robin arbiter with ptr register, grant, and update-on-accept.
- FSM, counter and datapath registers stay in mult_seq_arb.
- Bench instantiates mult_seq_arb together with the shift multiplier, mul_load driving its slow input.

Test Plan:
- Reset, then req0 a=0x0D b=0x0B, rsp_ready=1 -> rsp_valid rises exactly 10 cycles after accept, rsp_y=0x008F, rsp_id=0, mul_load high exactly one cycle.
- Corners on req1: 0xFF*0xFF, 0x00*0xA5, 0x80*0x02, 0x01*0xFF -> 0xFE01, 0x0000, 0x0100, 0x00FF; rsp_id=1.
- Both requesters valid continuously: req0 a=3 b=5, req1 a=7 b=9 -> grants alternate 0,1,0,1 starting with 0. Products 0x000F/0x003F with matching ids. req_ready is never high for both.
- rsp_ready held low 20 cycles after rsp_valid -> rsp_y/rsp_id stable, busy=1, req_ready=0 throughout. Release -> IDLE next cycle and new request accepted.
- rst_n pulsed low during SHIFT cycle 4 -> all outputs 0 immediately (async). No stale rsp_valid afterwards. Next request 0x12*0x34 returns 0x03A8.
- Random 1000 requests with random valid/ready toggling -> every accepted request yields exactly one response, in order, with product = a*b.
